mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
- Shares one pipelined signed×unsigned multiplier (16-bit signed × 14-bit unsigned → 30-bit signed, ce-gated) between N_REQ requesters in a PEG compute stage.
- Arbitrates among the requesters round-robin and drives the multiplier operands and ce.
- Tracks the requester ID of every in-flight product in a shadow pipeline.
- Returns each product on a single tagged result stream with backpressure.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID; must satisfy 2^ID_W ≥ N_REQ.
- MUL_LAT, 3, number of ce-qualified rising edges from operands on mul_din0/mul_din1 to the product on mul_dout.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_a  in  16*N_REQ  signed operand A; requester i uses bits [16i+15:16i].
- req_b  in  14*N_REQ  unsigned operand B; requester i uses bits [14i+13:14i].
- mul_ce  out  1  multiplier clock enable.
- mul_din0  out  16  operand A to the multiplier.
- mul_din1  out  14  operand B to the multiplier.
- mul_dout  in  30  signed product from the multiplier.
- res_valid  out  1  result valid.
- res_ready  in  1  result accept.
- res_id  out  ID_W  index of the requester that issued this product.
- res_data  out  30  signed product.
- inflight  out  ID_W+2  number of valid entries in the shadow pipeline.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - Clears the shadow valid pipeline and sets the RR pointer to 0.
  - In-flight products are discarded and never appear on res_*.
  - During reset: req_ready=0, res_valid=0, inflight=0, mul_ce=1 (flushes multiplier stages harmlessly).
- Stall: stall = res_valid & ~res_ready; mul_ce = ~stall. When stall=1:
  - No grant is issued.
  - The shadow pipeline and RR pointer hold.
  - res_* are held stable.
- Arbitration (combinational):
  - When mul_ce=1, grant the lowest i ≥ ptr, wrapping modulo N_REQ, with req_valid[i]=1.
  - req_ready = one-hot grant, or 0 if no valid request or stall.
  - Transfer occurs when req_valid[i] & req_ready[i].
- Operands:
  - mul_din0/mul_din1 = granted requester's req_a/req_b.
  - When there is no grant, drive 0/0; the resulting bubble is marked invalid.
- RR pointer: on a transfer from requester g, ptr ← (g+1) mod N_REQ. With no transfer, ptr holds.
- Shadow pipeline:
  - MUL_LAT stages of {vld, id}, advancing only when mul_ce=1.
  - Stage 0 loads {transfer, g}; the last stage drives res_valid/res_id.
  - res_data = mul_dout, passed through combinationally.
- Latency: a product accepted at edge k (no stalls) appears with res_valid=1 in the cycle after edge k+MUL_LAT−1, i.e. MUL_LAT cycles after acceptance. Each stall cycle adds 1.
- Throughput: 1 product per cycle when res_ready=1.
- Ordering: results leave in grant order. A requester never gets two grants while another valid requester waits, assuming continuous requests.
- Bubbles: when no request is valid, mul_ce stays 1 and invalid bubbles shift through; res_valid=0 for those slots.
- inflight = popcount of shadow vld. Maximum is MUL_LAT.
- Simultaneous output stall and new request: the request is not accepted; it must remain valid (requesters obey valid-hold).
- Arithmetic: product = signed(a) × zero-extended(b), 30-bit signed. The block only routes it; no width change.

Test Plan:
- Single requester, req 2 valid, a=−3 (0xFFFD), b=1000, res_ready=1 → res_valid=1 exactly MUL_LAT cycles after accept, res_id=2, res_data=−3000 (0x3FFFF448), inflight returns to 0.
- All 4 requesters valid continuously with a=i+1, b=10, for 8 cycles → grants 0,1,2,3,0,1,2,3; res_id sequence identical; res_data 10,20,30,40,… with one result per cycle.
- Backpressure: 3 products in flight, res_ready=0 for 5 cycles → mul_ce=0, req_ready=0, res_valid/res_id/res_data held, inflight=3. On release → the remaining products drain in order with no loss or duplication.
- Extremes: a=−32768, b=16383 → res_data=−536838144; a=32767, b=16383 → res_data=536821761.
- Sparse traffic: req 1 valid on cycles 0 and 5 only → exactly 2 results with gaps of res_valid=0. RR pointer=2 after each, so a later simultaneous req0+req3 grants 3 first.
- reset_n low for 1 cycle with 2 products in flight → no res_valid for those products, inflight=0, next accepted request comes from the lowest valid index ≥ 0.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined 16x14 multiplier between N_REQ requesters.
// A shadow {vld,id} pipeline tags each product and drives a backpressured result stream.
module mul_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [16*N_REQ-1:0]   req_a,
    input  logic [14*N_REQ-1:0]   req_b,
    output logic                  mul_ce,
    output logic [15:0]           mul_din0,
    output logic [13:0]           mul_din1,
    input  logic [29:0]           mul_dout,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ID_W-1:0]       res_id,
    output logic [29:0]           res_data,
    output logic [ID_W+1:0]       inflight
);

    logic [ID_W-1:0]                ptr_q, ptr_d;
    logic [MUL_LAT-1:0]             vld_q, vld_d;
    logic [MUL_LAT-1:0][ID_W-1:0]   id_q, id_d;

    logic            stall;
    logic            gnt_any;
    logic            gnt_ok;
    logic [ID_W-1:0] gnt_id;
    logic            hi_found;
    logic [ID_W-1:0] hi_id;
    logic            lo_found;
    logic [ID_W-1:0] lo_id;
    logic            xfer;
    logic [ID_W+1:0] cnt;

    // Result side: the last shadow stage tags the product leaving the multiplier.
    always_comb begin
        res_valid = reset_n & vld_q[MUL_LAT-1];
        res_id    = id_q[MUL_LAT-1];
        res_data  = mul_dout;
        stall     = res_valid & ~res_ready;
        mul_ce    = ~stall;
    end

    // Two passes: first valid at or above the pointer, else first valid overall.
    always_comb begin
        hi_found = 1'b0;
        hi_id    = '0;
        lo_found = 1'b0;
        lo_id    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!hi_found && req_valid[i] && (ID_W'(i) >= ptr_q)) begin
                hi_found = 1'b1;
                hi_id    = ID_W'(i);
            end
            if (!lo_found && req_valid[i]) begin
                lo_found = 1'b1;
                lo_id    = ID_W'(i);
            end
        end
        gnt_any = lo_found;
        gnt_id  = hi_found ? hi_id : lo_id;
        gnt_ok  = gnt_any & ~stall & reset_n;
    end

    always_comb begin
        req_ready = '0;
        mul_din0  = '0;
        mul_din1  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = gnt_ok & (gnt_id == ID_W'(i));
            if (req_ready[i]) begin
                mul_din0 = req_a[16*i +: 16];
                mul_din1 = req_b[14*i +: 14];
            end
        end
        xfer = |(req_valid & req_ready);
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        end
    end

    // The shadow pipeline moves in lockstep with the multiplier's ce.
    always_comb begin
        vld_d = vld_q;
        id_d  = id_q;
        if (mul_ce) begin
            for (int i = MUL_LAT - 1; i > 0; i--) begin
                vld_d[i] = vld_q[i-1];
                id_d[i]  = id_q[i-1];
            end
            vld_d[0] = xfer;
            id_d[0]  = gnt_id;
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < MUL_LAT; i++) begin
            cnt = cnt + (ID_W+2)'(vld_q[i]);
        end
        inflight = reset_n ? cnt : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q <= '0;
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: external pipelined multiplier model,
// table vectors, directed corner sequences and a queue-based random check.
module tb_mul_share_arbiter;

    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int MUL_LAT = 3;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [16*N_REQ-1:0] req_a;
    logic [14*N_REQ-1:0] req_b;
    logic                mul_ce;
    logic [15:0]         mul_din0;
    logic [13:0]         mul_din1;
    logic [29:0]         mul_dout;
    logic                res_valid;
    logic                res_ready;
    logic [ID_W-1:0]     res_id;
    logic [29:0]         res_data;
    logic [ID_W+1:0]     inflight;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_share_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
        .mul_dout(mul_dout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_data(res_data), .inflight(inflight)
    );

    // Multiplier: MUL_LAT ce-gated register stages, signed x zero-extended.
    logic [29:0] mreg [MUL_LAT];
    logic signed [29:0] mfull;
    always_comb mfull = $signed(mul_din0) * $signed({1'b0, mul_din1});
    always @(posedge clk) begin
        if (mul_ce) begin
            mreg[0] <= mfull;
            for (int k = 1; k < MUL_LAT; k++) mreg[k] <= mreg[k-1];
        end
    end
    assign mul_dout = mreg[MUL_LAT-1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [13:0] b);
        req_a[16*i +: 16] = a;
        req_b[14*i +: 14] = b;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        res_ready = 1'b1;
        cyc();
        cyc();
        reset_n = 1'b1;
    endtask

    function automatic logic [29:0] prod(input logic [15:0] a, input logic [13:0] b);
        int pa;
        int pb;
        pa = int'($signed(a));
        pb = int'(b);
        return 30'(pa * pb);
    endfunction

    typedef struct {
        int          req;
        logic [15:0] a;
        logic [13:0] b;
        int          exp_id;
        logic [29:0] exp;
    } vec_t;

    typedef struct {
        int          id;
        logic [29:0] p;
        int          age;
    } ent_t;

    vec_t vt[6];
    ent_t q[$];
    int   ptr_m;
    logic [N_REQ-1:0] hold;

    initial begin
        vt[0] = '{2, 16'hFFFD, 14'd1000,  2, 30'h3FFFF448};
        vt[1] = '{0, 16'h8000, 14'd16383, 0, 30'(-536838144)};
        vt[2] = '{3, 16'h7FFF, 14'd16383, 3, 30'd536821761};
        vt[3] = '{1, 16'd100,  14'd100,   1, 30'd10000};
        vt[4] = '{2, 16'hFFFF, 14'd16383, 2, 30'(-16383)};
        vt[5] = '{1, 16'd7,    14'd0,     1, 30'd0};

        reset_n   = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        @(negedge clk);
        cyc();
        #1;
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_valid", 64'(res_valid), 64'(0));
        chk("rst_inflight", 64'(inflight), 64'(0));
        chk("rst_ce", 64'(mul_ce), 64'(1));
        do_reset();

        // Table vectors: single requester, latency and product.
        for (int v = 0; v < 6; v++) begin
            bit found;
            req_valid = N_REQ'(1) << vt[v].req;
            set_op(vt[v].req, vt[v].a, vt[v].b);
            #1;
            chk("vec_ready", 64'(req_ready), 64'(N_REQ'(1) << vt[v].req));
            cyc();
            req_valid = '0;
            found = 1'b0;
            for (int n = 1; n <= 8; n++) begin
                #1;
                if (res_valid) begin
                    chk("vec_latency", 64'(n), 64'(MUL_LAT));
                    chk("vec_id", 64'(res_id), 64'(vt[v].exp_id));
                    chk("vec_data", 64'(res_data), 64'(vt[v].exp));
                    found = 1'b1;
                    break;
                end
                cyc();
            end
            if (!found) begin
                checks++;
                errors++;
                $display("FAIL vec_timeout: no res_valid for vector %0d", v);
            end
            cyc();
            #1;
            chk("vec_inflight0", 64'(inflight), 64'(0));
            chk("vec_valid0", 64'(res_valid), 64'(0));
            cyc();
        end

        // Round robin with all requesters busy.
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_op(i, 16'(i + 1), 14'd10);
        for (int c = 0; c < 8 + MUL_LAT + 1; c++) begin
            req_valid = (c < 8) ? '1 : '0;
            #1;
            if (c < 8)
                chk("rr_grant", 64'(req_ready), 64'(N_REQ'(1) << (c % N_REQ)));
            if (c >= MUL_LAT && c < 8 + MUL_LAT) begin
                chk("rr_valid", 64'(res_valid), 64'(1));
                chk("rr_id", 64'(res_id), 64'((c - MUL_LAT) % N_REQ));
                chk("rr_data", 64'(res_data), 64'(30'((((c - MUL_LAT) % N_REQ) + 1) * 10)));
            end else if (c >= 8 + MUL_LAT) begin
                chk("rr_idle", 64'(res_valid), 64'(0));
            end
            cyc();
        end

        // Backpressure with three products in flight.
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_op(i, 16'(100 + i), 14'd3);
        for (int c = 0; c < 13; c++) begin
            case (c)
                0: req_valid = 4'b0001;
                1: req_valid = 4'b0010;
                2: req_valid = 4'b0100;
                3, 4, 5, 6, 7, 8: req_valid = 4'b1000;
                default: req_valid = '0;
            endcase
            res_ready = !(c >= 3 && c <= 7);
            #1;
            if (c >= 3 && c <= 7) begin
                chk("bp_ce", 64'(mul_ce), 64'(0));
                chk("bp_ready", 64'(req_ready), 64'(0));
                chk("bp_valid", 64'(res_valid), 64'(1));
                chk("bp_id", 64'(res_id), 64'(0));
                chk("bp_data", 64'(res_data), 64'(30'd300));
                chk("bp_inflight", 64'(inflight), 64'(3));
            end
            if (c == 8) chk("bp_release", 64'(req_ready), 64'(4'b1000));
            if (c >= 8 && c <= 11) begin
                chk("drain_valid", 64'(res_valid), 64'(1));
                chk("drain_id", 64'(res_id), 64'(c - 8));
                chk("drain_data", 64'(res_data), 64'(30'((100 + c - 8) * 3)));
            end
            if (c == 12) begin
                chk("drain_done", 64'(res_valid), 64'(0));
                chk("drain_inflight", 64'(inflight), 64'(0));
            end
            cyc();
        end

        // Sparse traffic from requester 1, then pointer check.
        do_reset();
        set_op(1, 16'd5, 14'd7);
        set_op(0, 16'd1, 14'd1);
        set_op(3, 16'd2, 14'd2);
        for (int c = 0; c < 11; c++) begin
            req_valid = (c == 0 || c == 5) ? 4'b0010 : 4'b0000;
            #1;
            chk("sp_valid", 64'(res_valid), 64'(c == 3 || c == 8));
            if (c == 3 || c == 8) begin
                chk("sp_id", 64'(res_id), 64'(1));
                chk("sp_data", 64'(res_data), 64'(30'd35));
            end
            cyc();
        end
        req_valid = 4'b1001;
        #1;
        chk("sp_ptr_first", 64'(req_ready), 64'(4'b1000));
        cyc();
        req_valid = 4'b0001;
        #1;
        chk("sp_ptr_second", 64'(req_ready), 64'(4'b0001));
        cyc();
        req_valid = '0;
        for (int c = 0; c < 5; c++) cyc();

        // Reset with two products in flight.
        do_reset();
        set_op(1, 16'd2, 14'd2);
        set_op(2, 16'd3, 14'd3);
        req_valid = 4'b0010;
        #1;
        chk("ri_g1", 64'(req_ready), 64'(4'b0010));
        cyc();
        req_valid = 4'b0100;
        #1;
        chk("ri_g2", 64'(req_ready), 64'(4'b0100));
        cyc();
        reset_n   = 1'b0;
        req_valid = 4'b1001;
        #1;
        chk("ri_ready", 64'(req_ready), 64'(0));
        chk("ri_valid", 64'(res_valid), 64'(0));
        chk("ri_inflight", 64'(inflight), 64'(0));
        chk("ri_ce", 64'(mul_ce), 64'(1));
        cyc();
        reset_n   = 1'b1;
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("ri_flushed", 64'(res_valid), 64'(0));
            chk("ri_empty", 64'(inflight), 64'(0));
            cyc();
        end
        req_valid = 4'b1010;
        #1;
        chk("ri_lowest", 64'(req_ready), 64'(4'b0010));
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        #1;
        chk("ri_res_valid", 64'(res_valid), 64'(1));
        chk("ri_res_id", 64'(res_id), 64'(1));
        chk("ri_res_data", 64'(res_data), 64'(30'd4));
        cyc();

        // Random traffic against a queue-of-products reference.
        do_reset();
        q.delete();
        ptr_m = 0;
        hold  = '0;
        for (int t = 0; t < 3000; t++) begin
            bit          exp_rv;
            bit          exp_stall;
            int          g;
            logic [15:0] ga;
            logic [13:0] gb;
            reset_n   = ($urandom_range(0, 299) != 0);
            res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N_REQ; i++) begin
                if (!hold[i]) begin
                    req_valid[i] = $urandom_range(0, 1) == 1;
                    set_op(i, 16'($urandom), 14'($urandom));
                end
            end
            #1;
            exp_rv    = reset_n && q.size() > 0 && q[0].age == MUL_LAT - 1;
            exp_stall = exp_rv && !res_ready;
            g = -1;
            if (reset_n && !exp_stall) begin
                for (int off = 0; off < N_REQ; off++) begin
                    int idx;
                    idx = (ptr_m + off) % N_REQ;
                    if (req_valid[idx]) begin
                        g = idx;
                        break;
                    end
                end
            end
            chk("rnd_ready", 64'(req_ready), 64'(g >= 0 ? (N_REQ'(1) << g) : N_REQ'(0)));
            chk("rnd_ce", 64'(mul_ce), 64'(!exp_stall));
            chk("rnd_valid", 64'(res_valid), 64'(exp_rv));
            chk("rnd_inflight", 64'(inflight), 64'(reset_n ? q.size() : 0));
            if (exp_rv) begin
                chk("rnd_id", 64'(res_id), 64'(q[0].id));
                chk("rnd_data", 64'(res_data), 64'(q[0].p));
            end
            ga = '0;
            gb = '0;
            if (g >= 0) begin
                ga = req_a[16*g +: 16];
                gb = req_b[14*g +: 14];
                chk("rnd_din0", 64'(mul_din0), 64'(ga));
                chk("rnd_din1", 64'(mul_din1), 64'(gb));
            end
            @(posedge clk);
            if (!reset_n) begin
                q.delete();
                ptr_m = 0;
            end else if (!exp_stall) begin
                if (exp_rv) void'(q.pop_front());
                foreach (q[k]) q[k].age = q[k].age + 1;
                if (g >= 0) begin
                    q.push_back('{g, prod(ga, gb), 0});
                    ptr_m = (g + 1) % N_REQ;
                end
            end
            for (int i = 0; i < N_REQ; i++) hold[i] = req_valid[i] && (i != g);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
